dm_cache_ctrl: RTL and testbench

- Blocking write-back, write-allocate controller for the direct-mapped cache.
- Sequences the single-port 1024-line tag and data memories.
- Serves one CPU word request at a time and moves whole 128-bit lines to and from main memory over a valid/ready handshake.
- Sits between the CPU request interface and the tag/data arrays plus the memory port.

---
 rtl/dm_cache_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dm_cache_ctrl
// Description : Blocking write-back, write-allocate controller for a
//               direct-mapped cache. It drives single-port tag/data arrays and
//               moves whole lines to/from main memory over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_cache_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 10,
    parameter int OFFSET_W = 4,
    parameter int LINE_W   = 128
) (
    input  logic                                 clk,
    input  logic                                 rst,
    // CPU side
    input  logic [ADDR_W-1:0]                    cpu_addr_i,
    input  logic [31:0]                          cpu_wdata_i,
    input  logic                                 cpu_rw_i,
    input  logic                                 cpu_valid_i,
    output logic [31:0]                          cpu_rdata_o,
    output logic                                 cpu_ready_o,
    // Memory side
    output logic [ADDR_W-1:0]                    mem_addr_o,
    output logic [LINE_W-1:0]                    mem_wdata_o,
    output logic                                 mem_rw_o,
    output logic                                 mem_valid_o,
    input  logic [LINE_W-1:0]                    mem_rdata_i,
    input  logic                                 mem_ready_i,
    // Tag array
    output logic [INDEX_W-1:0]                   tag_index_o,
    output logic                                 tag_we_o,
    output logic [(ADDR_W-INDEX_W-OFFSET_W)+1:0] tag_wdata_o,
    input  logic [(ADDR_W-INDEX_W-OFFSET_W)+1:0] tag_rdata_i,
    // Data array
    output logic [INDEX_W-1:0]                   data_index_o,
    output logic                                 data_we_o,
    output logic [LINE_W-1:0]                    data_wdata_o,
    input  logic [LINE_W-1:0]                    data_rdata_i
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int POS_W = $clog2(LINE_W);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_COMPARE    = 2'd1,
        S_WRITE_BACK = 2'd2,
        S_ALLOCATE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   victim_q, victim_d;
    // Forces one idle memory cycle between a write-back and the fill request.
    logic                gap_q, gap_d;

    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_req_tag;
    logic [POS_W-1:0]    w_bitpos;
    logic                w_hit;
    logic                w_dirty_victim;
    logic [LINE_W-1:0]   w_merged;
    logic                w_unused;

    assign w_index        = addr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign w_req_tag      = addr_q[ADDR_W-1:ADDR_W-TAG_W];
    assign w_bitpos       = {addr_q[OFFSET_W-1:2], 5'b0};
    assign w_hit          = tag_rdata_i[TAG_W+1] && (tag_rdata_i[TAG_W-1:0] == w_req_tag);
    assign w_dirty_victim = tag_rdata_i[TAG_W+1] && tag_rdata_i[TAG_W];
    // Byte-lane bits of the CPU address carry no meaning for word accesses.
    assign w_unused       = ^addr_q[1:0];

    // Current line with the selected word replaced by the store data.
    always_comb begin
        w_merged                 = data_rdata_i;
        w_merged[w_bitpos +: 32] = wdata_q;
    end

    // State and request registers; asynchronous reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rw_q     <= 1'b0;
            victim_q <= '0;
            gap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rw_q     <= rw_d;
            victim_q <= victim_d;
            gap_q    <= gap_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rw_d         = rw_q;
        victim_d     = victim_q;
        gap_d        = gap_q;
        cpu_rdata_o  = '0;
        cpu_ready_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_rw_o     = 1'b0;
        mem_valid_o  = 1'b0;
        tag_index_o  = w_index;
        tag_we_o     = 1'b0;
        tag_wdata_o  = '0;
        data_index_o = w_index;
        data_we_o    = 1'b0;
        data_wdata_o = '0;

        case (state_q)
            S_IDLE: begin
                if (cpu_valid_i) begin
                    addr_d  = cpu_addr_i;
                    wdata_d = cpu_wdata_i;
                    rw_d    = cpu_rw_i;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_hit) begin
                    cpu_ready_o = 1'b1;
                    if (rw_q) begin
                        data_we_o    = 1'b1;
                        data_wdata_o = w_merged;
                        tag_we_o     = 1'b1;
                        tag_wdata_o  = {1'b1, 1'b1, w_req_tag};
                    end else begin
                        cpu_rdata_o = data_rdata_i[w_bitpos +: 32];
                    end
                    state_d = S_IDLE;
                end else if (w_dirty_victim) begin
                    victim_d = {tag_rdata_i[TAG_W-1:0], w_index, {OFFSET_W{1'b0}}};
                    state_d  = S_WRITE_BACK;
                end else begin
                    gap_d   = 1'b0;
                    state_d = S_ALLOCATE;
                end
            end
            S_WRITE_BACK: begin
                mem_valid_o = 1'b1;
                mem_rw_o    = 1'b1;
                mem_addr_o  = victim_q;
                mem_wdata_o = data_rdata_i;
                if (mem_ready_i) begin
                    gap_d   = 1'b1;
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    mem_valid_o = 1'b1;
                    mem_addr_o  = {w_req_tag, w_index, {OFFSET_W{1'b0}}};
                    if (mem_ready_i) begin
                        data_we_o    = 1'b1;
                        data_wdata_o = mem_rdata_i;
                        tag_we_o     = 1'b1;
                        tag_wdata_o  = {1'b1, 1'b0, w_req_tag};
                        state_d      = S_COMPARE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_cache_ctrl
// Description : Directed bench for dm_cache_ctrl with behavioural tag/data
//               arrays and a hand-driven memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic         cpu_rw = 1'b0;
    logic         cpu_valid = 1'b0;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_rw;
    logic         mem_valid;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic [9:0]   tag_index;
    logic         tag_we;
    logic [19:0]  tag_wdata;
    logic [19:0]  tag_rdata;
    logic [9:0]   data_index;
    logic         data_we;
    logic [127:0] data_wdata;
    logic [127:0] data_rdata;

    logic         mem_clr = 1'b1;
    logic [19:0]  tag_mem  [1024];
    logic [127:0] data_mem [1024];

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] L1 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    localparam logic [127:0] L1W = {32'h4444_4444, 32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111};
    localparam logic [127:0] L2 = {32'hAAAA_AAAA, 32'h9999_9999, 32'h5555_5555, 32'h7777_7777};
    localparam logic [127:0] L3 = {32'hC0DE_0003, 32'hC0DE_0002, 32'h0BAD_F00D, 32'hC0DE_0000};
    localparam logic [127:0] L4 = {32'hFEED_0003, 32'hFEED_0002, 32'hFEED_0001, 32'hFEED_0000};

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_rw_i     (cpu_rw),
        .cpu_valid_i  (cpu_valid),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_ready_o  (cpu_ready),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rw_o     (mem_rw),
        .mem_valid_o  (mem_valid),
        .mem_rdata_i  (mem_rdata),
        .mem_ready_i  (mem_ready),
        .tag_index_o  (tag_index),
        .tag_we_o     (tag_we),
        .tag_wdata_o  (tag_wdata),
        .tag_rdata_i  (tag_rdata),
        .data_index_o (data_index),
        .data_we_o    (data_we),
        .data_wdata_o (data_wdata),
        .data_rdata_i (data_rdata)
    );

    // Behavioural single-port arrays with combinational read.
    assign tag_rdata  = tag_mem[tag_index];
    assign data_rdata = data_mem[data_index];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) begin
                tag_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (tag_we)  tag_mem[tag_index]   <= tag_wdata;
            if (data_we) data_mem[data_index] <= data_wdata;
        end
    end

    // Present one request to the controller; returns just after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic rw);
        @(negedge clk);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_rw    = rw;
        cpu_valid = 1'b1;
        @(posedge clk);
        #1 cpu_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({cpu_rdata, cpu_ready, mem_addr, mem_wdata, mem_rw, mem_valid, tag_index, tag_we,
             tag_wdata, data_index, data_we, data_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: mem_valid=%b cpu_ready=%b tag_we=%b data_we=%b mem_addr=%h (all must be 0)",
                     mem_valid, cpu_ready, tag_we, data_we, mem_addr);
        end
        rst     = 1'b0;
        mem_clr = 1'b0;
        // mem_ready while idle must be ignored
        mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total++;
            if ({mem_valid, cpu_ready, tag_we, data_we} !== 4'b0) begin
                bad++;
                $display("FAIL idle_mem_ready: mem_valid=%b cpu_ready=%b tag_we=%b data_we=%b want 0",
                         mem_valid, cpu_ready, tag_we, data_we);
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_cold_read();
        issue(32'h0000_1234, 32'h0, 1'b0);
        @(negedge clk);
        total++;
        if (cpu_ready !== 1'b0 || mem_valid !== 1'b0 || tag_we !== 1'b0) begin
            bad++;
            $display("FAIL cold_compare: cpu_ready=%b mem_valid=%b tag_we=%b want 0/0/0", cpu_ready, mem_valid, tag_we);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_1230 || mem_rw !== 1'b0 || tag_we !== 1'b0) begin
                bad++;
                $display("FAIL cold_alloc_req: valid=%b addr=%h rw=%b tag_we=%b want 1/00001230/0/0",
                         mem_valid, mem_addr, mem_rw, tag_we);
            end
        end
        @(negedge clk);
        mem_rdata = L1;
        mem_ready = 1'b1;
        #1;
        total++;
        if (tag_we !== 1'b1 || tag_wdata !== 20'h80000 || data_we !== 1'b1 || data_wdata !== L1) begin
            bad++;
            $display("FAIL cold_fill_write: tag_we=%b tag_wdata=%h data_we=%b data_wdata=%h want 1/80000/1/%h",
                     tag_we, tag_wdata, data_we, data_wdata, L1);
        end
        @(posedge clk);
        #1 mem_ready = 1'b0;
        total++;
        if (tag_mem[10'h123] !== 20'h80000) begin
            bad++;
            $display("FAIL cold_tag_stored: got %h want 80000", tag_mem[10'h123]);
        end
        @(negedge clk);
        total++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h2222_2222 || mem_valid !== 1'b0) begin
            bad++;
            $display("FAIL cold_rdata: ready=%b rdata=%h mem_valid=%b want 1/22222222/0", cpu_ready, cpu_rdata, mem_valid);
        end
        @(negedge clk);
        total++;
        if (cpu_ready !== 1'b0 || cpu_rdata !== 32'h0) begin
            bad++;
            $display("FAIL ready_pulse: ready=%b rdata=%h want 0/00000000", cpu_ready, cpu_rdata);
        end
    endtask

    task automatic test_read_hit();
        issue(32'h0000_1238, 32'h0, 1'b0);
        @(negedge clk);
        total++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h3333_3333 || mem_valid !== 1'b0 ||
            tag_we !== 1'b0 || data_we !== 1'b0) begin
            bad++;
            $display("FAIL read_hit: ready=%b rdata=%h mem_valid=%b tag_we=%b data_we=%b want 1/33333333/0/0/0",
                     cpu_ready, cpu_rdata, mem_valid, tag_we, data_we);
        end
        @(negedge clk);
        total++;
        if (cpu_ready !== 1'b0 || mem_valid !== 1'b0) begin
            bad++;
            $display("FAIL read_hit_idle: ready=%b mem_valid=%b want 0/0", cpu_ready, mem_valid);
        end
    endtask

    task automatic test_write_hit();
        issue(32'h0000_1234, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        total++;
        if (cpu_ready !== 1'b1 || data_we !== 1'b1 || data_wdata !== L1W || tag_we !== 1'b1 ||
            tag_wdata !== 20'hC0000 || mem_valid !== 1'b0) begin
            bad++;
            $display("FAIL write_hit: ready=%b data_we=%b wdata=%h tag_we=%b tag_wdata=%h want 1/1/%h/1/c0000",
                     cpu_ready, data_we, data_wdata, tag_we, tag_wdata, L1W);
        end
        @(posedge clk);
        #1;
        total++;
        if (tag_mem[10'h123] !== 20'hC0000 || data_mem[10'h123][63:32] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL write_hit_stored: tag=%h word1=%h want c0000/deadbeef",
                     tag_mem[10'h123], data_mem[10'h123][63:32]);
        end
    endtask

    task automatic test_dirty_evict();
        issue(32'h0000_5234, 32'h0, 1'b0);
        @(negedge clk);
        total++;
        if (cpu_ready !== 1'b0 || mem_valid !== 1'b0) begin
            bad++;
            $display("FAIL evict_compare: ready=%b mem_valid=%b want 0/0", cpu_ready, mem_valid);
        end
        @(negedge clk);
        total++;
        if (mem_valid !== 1'b1 || mem_rw !== 1'b1 || mem_addr !== 32'h0000_1230 ||
            mem_wdata[63:32] !== 32'hDEAD_BEEF || mem_wdata !== L1W) begin
            bad++;
            $display("FAIL writeback_req: valid=%b rw=%b addr=%h wdata=%h want 1/1/00001230/%h",
                     mem_valid, mem_rw, mem_addr, mem_wdata, L1W);
        end
        mem_ready = 1'b1;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (mem_valid !== 1'b0) begin
            bad++;
            $display("FAIL valid_gap: mem_valid=%b want 0", mem_valid);
        end
        @(negedge clk);
        total++;
        if (mem_valid !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== 32'h0000_5230) begin
            bad++;
            $display("FAIL evict_alloc_req: valid=%b rw=%b addr=%h want 1/0/00005230", mem_valid, mem_rw, mem_addr);
        end
        mem_rdata = L2;
        mem_ready = 1'b1;
        #1;
        total++;
        if (tag_we !== 1'b1 || tag_wdata !== 20'h80001 || data_we !== 1'b1 || data_wdata !== L2) begin
            bad++;
            $display("FAIL evict_fill_write: tag_we=%b tag_wdata=%h data_we=%b want 1/80001/1", tag_we, tag_wdata, data_we);
        end
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h5555_5555) begin
            bad++;
            $display("FAIL evict_rdata: ready=%b rdata=%h want 1/55555555", cpu_ready, cpu_rdata);
        end
    endtask

    task automatic test_stall();
        int errs;
        issue(32'h0000_9234, 32'h0, 1'b0);
        @(negedge clk);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_9230 || mem_rw !== 1'b0 ||
                cpu_ready !== 1'b0 || tag_we !== 1'b0 || data_we !== 1'b0) begin
                bad++;
                errs++;
                if (errs < 4)
                    $display("FAIL stall_hold cycle %0d: valid=%b addr=%h rw=%b ready=%b tag_we=%b data_we=%b want 1/00009230/0/0/0/0",
                             i, mem_valid, mem_addr, mem_rw, cpu_ready, tag_we, data_we);
            end
        end
        mem_rdata = L3;
        mem_ready = 1'b1;
        #1;
        total++;
        if (tag_we !== 1'b1 || tag_wdata !== 20'h80002 || data_we !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: tag_we=%b tag_wdata=%h data_we=%b want 1/80002/1", tag_we, tag_wdata, data_we);
        end
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL stall_rdata: ready=%b rdata=%h want 1/0badf00d", cpu_ready, cpu_rdata);
        end
    endtask

    task automatic test_reset_mid_alloc();
        issue(32'h0000_D234, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_D230) begin
            bad++;
            $display("FAIL rst_alloc_req: valid=%b addr=%h want 1/0000d230", mem_valid, mem_addr);
        end
        mem_rdata = L4;
        mem_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        total++;
        if (mem_valid !== 1'b0 || tag_we !== 1'b0 || data_we !== 1'b0 || cpu_ready !== 1'b0 || tag_index !== 10'h0) begin
            bad++;
            $display("FAIL rst_immediate: valid=%b tag_we=%b data_we=%b ready=%b tag_index=%h want 0/0/0/0/000",
                     mem_valid, tag_we, data_we, cpu_ready, tag_index);
        end
        @(posedge clk);
        #1 mem_ready = 1'b0;
        total++;
        if (tag_mem[10'h123] !== 20'h80002 || data_mem[10'h123] !== L3) begin
            bad++;
            $display("FAIL rst_no_write: tag=%h want 80002", tag_mem[10'h123]);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(32'h0000_D234, 32'h0, 1'b0);
        @(negedge clk);
        total++;
        if (cpu_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_remiss: ready=%b want 0", cpu_ready);
        end
        @(negedge clk);
        total++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_D230 || mem_rw !== 1'b0) begin
            bad++;
            $display("FAIL rst_realloc: valid=%b addr=%h rw=%b want 1/0000d230/0", mem_valid, mem_addr, mem_rw);
        end
        mem_ready = 1'b1;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hFEED_0001) begin
            bad++;
            $display("FAIL rst_refill_rdata: ready=%b rdata=%h want 1/feed0001", cpu_ready, cpu_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_hit();
        test_dirty_evict();
        test_stall();
        test_reset_mid_alloc();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
